// File: rtl/water_fill_controller.sv
// ---------------------------------------------------------------------------
// water_fill_controller: latches a fill target, opens the inlet valve, counts
// flow-meter pulses, settles, then pulses fill_done. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module water_fill_controller #(
  parameter int TIMEOUT_CYCLES = 50,
  parameter int SETTLE_CYCLES  = 10,
  parameter int MAX_LEVEL      = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       clear_fault,
  input  logic [9:0] water_level,
  input  logic       flow_pulse,
  output logic       inlet_valve,
  output logic       busy,
  output logic       fill_done,
  output logic       fill_fault,
  output logic [9:0] filled_volume
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [9:0]    C_MAX_LEVEL = 10'(MAX_LEVEL);
  localparam logic [TW-1:0] C_TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] C_ST_LAST   = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_SETTLE = 3'd2,
    S_DONE   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    target_q, target_d;
  logic [9:0]    volume_q, volume_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          flow_prev_q;
  logic          valve_q, busy_q, done_q, fault_q;

  logic          w_edge;
  logic [9:0]    w_vol_inc;
  logic [9:0]    w_clamped;
  logic          w_reached;

  assign w_edge    = flow_pulse & ~flow_prev_q;
  assign w_vol_inc = (volume_q == 10'h3FF) ? volume_q : volume_q + 10'd1;
  assign w_clamped = (water_level > C_MAX_LEVEL) ? C_MAX_LEVEL : water_level;
  // Compare in 11 bits so volume 1023 + 1 cannot wrap below the target.
  assign w_reached = ({1'b0, volume_q} + 11'd1) >= {1'b0, target_q};

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    volume_d  = volume_q;
    timeout_d = timeout_q;
    settle_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          target_d  = w_clamped;
          volume_d  = '0;
          timeout_d = '0;
          state_d   = (w_clamped == 10'd0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (w_edge) begin
          volume_d  = w_vol_inc;
          timeout_d = '0;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
        if (abort) begin
          state_d = S_IDLE;
        end else if (w_edge && w_reached) begin
          state_d = S_SETTLE;
        end else if (!w_edge && (timeout_q == C_TO_LAST)) begin
          state_d = S_FAULT;
        end
      end
      S_SETTLE: begin
        // Overshoot after the valve closes is still metered.
        if (w_edge) begin
          volume_d = w_vol_inc;
        end
        if (abort) begin
          state_d = S_IDLE;
        end else if (settle_q == C_ST_LAST) begin
          state_d = S_DONE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (clear_fault) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      volume_q    <= '0;
      timeout_q   <= '0;
      settle_q    <= '0;
      flow_prev_q <= 1'b0;
      valve_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      volume_q    <= volume_d;
      timeout_q   <= timeout_d;
      settle_q    <= settle_d;
      flow_prev_q <= flow_pulse;
      valve_q     <= (state_d == S_FILL);
      busy_q      <= (state_d == S_FILL) || (state_d == S_SETTLE);
      done_q      <= (state_d == S_DONE);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign inlet_valve   = valve_q;
  assign busy          = busy_q;
  assign fill_done     = done_q;
  assign fill_fault    = fault_q;
  assign filled_volume = volume_q;

endmodule

`default_nettype wire
